// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control FSM for the MIPS core.
// Sequences fetch/decode/execute/memory/writeback from the op/func fields of
// the latched IR, drives datapath write enables, mux selects and the memory
// request handshakes, counts retired instructions and flags illegal opcodes
// and memory timeouts.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   op, func                IR opcode / function fields
//   alu_zero                ALU equal flag (beq)
//   imem_ready, dmem_ready  memory handshakes
//   imem_req, dmem_req, dmem_we
//   pc_we, ir_we, reg_we    datapath write enables
//   alu_op, alu_src_b, ext_op, reg_dst, wd_sel, pc_src   mux selects
//   state                   current state
//   illegal                 one-cycle pulse on unknown instruction
//   bus_err                 sticky memory timeout flag
//   retired                 retired-instruction count
//
// state  | meaning
// IDLE   | after reset; parked here forever once bus_err is set
// FETCH  | instruction request, wait for imem_ready, latch IR, PC+4
// DECODE | resolve j/jal/jr, flag illegal, else go to EXEC
// EXEC   | ALU operation; beq resolves here
// MEM    | data access for lw/sw, wait for dmem_ready
// WB     | register file write

module mc_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic [2:0]       alu_op,
    output logic             alu_src_b,
    output logic             ext_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_SLL   = 6'h00;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;
    localparam logic [2:0] ALU_SLL = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   retired_q;
    logic               retire;

    logic is_rtype, is_addu, is_subu, is_jr, is_sll, is_rcalc;
    logic is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal, is_legal;

    assign is_rtype = (op == OP_RTYPE);
    assign is_addu  = is_rtype && (func == FN_ADDU);
    assign is_subu  = is_rtype && (func == FN_SUBU);
    assign is_jr    = is_rtype && (func == FN_JR);
    assign is_sll   = is_rtype && (func == FN_SLL);
    assign is_rcalc = is_addu | is_subu | is_sll;
    assign is_ori   = (op == OP_ORI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_lui   = (op == OP_LUI);
    assign is_j     = (op == OP_J);
    assign is_jal   = (op == OP_JAL);
    assign is_legal = is_rcalc | is_jr | is_ori | is_lw | is_sw | is_beq
                    | is_lui | is_j | is_jal;

    // ALU selects shared by EXEC and MEM (MEM holds the address computation)
    logic [2:0] sel_alu_op;
    logic       sel_src_b;
    logic       sel_ext;

    always_comb begin
        sel_alu_op = ALU_ADD;
        sel_src_b  = 1'b0;
        sel_ext    = 1'b0;
        if (is_subu) begin
            sel_alu_op = ALU_SUB;
        end else if (is_sll) begin
            sel_alu_op = ALU_SLL;
        end else if (is_ori) begin
            sel_alu_op = ALU_OR;
            sel_src_b  = 1'b1;
        end else if (is_lui) begin
            sel_alu_op = ALU_LUI;
            sel_src_b  = 1'b1;
        end else if (is_lw || is_sw) begin
            sel_src_b  = 1'b1;
            sel_ext    = 1'b1;
        end else if (is_beq) begin
            sel_alu_op = ALU_SUB;
            sel_ext    = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        bus_err_d = bus_err_q;
        retire    = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        ext_op    = 1'b0;
        reg_dst   = 2'd0;
        wd_sel    = 2'd0;
        pc_src    = 2'd0;
        illegal   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!bus_err_q) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                if (!is_legal) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else if (is_j || is_jal) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd2;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                    if (is_jal) begin
                        // PC already advanced in FETCH, so it is the link value
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        wd_sel  = 2'd2;
                    end
                end else if (is_jr) begin
                    pc_we   = 1'b1;
                    pc_src  = 2'd3;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_op    = sel_alu_op;
                alu_src_b = sel_src_b;
                ext_op    = sel_ext;
                if (is_beq) begin
                    pc_we   = alu_zero;
                    pc_src  = 2'd1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                alu_op    = sel_alu_op;
                alu_src_b = sel_src_b;
                ext_op    = sel_ext;
                dmem_req  = 1'b1;
                dmem_we   = is_sw;
                if (dmem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = is_rcalc ? 2'd1 : 2'd0;
                wd_sel  = is_lw ? 2'd1 : 2'd0;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign state   = state_q;
    assign bus_err = bus_err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_MEM   = 3'd4;

    localparam int K_ADDU = 0, K_SUBU = 1, K_SLL = 2, K_JR = 3, K_ORI = 4, K_LW = 5;
    localparam int K_SW = 6, K_BEQ = 7, K_LUI = 8, K_J = 9, K_JAL = 10, K_ILL = 11;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [5:0]       op, func;
    logic             alu_zero, imem_ready, dmem_ready;
    logic             imem_req, dmem_req, dmem_we, pc_we, ir_we, reg_we;
    logic [2:0]       alu_op;
    logic             alu_src_b, ext_op;
    logic [1:0]       reg_dst, wd_sel, pc_src;
    logic [2:0]       state;
    logic             illegal, bus_err;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .func(func), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
        .alu_op(alu_op), .alu_src_b(alu_src_b), .ext_op(ext_op),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .pc_src(pc_src),
        .state(state), .illegal(illegal), .bus_err(bus_err), .retired(retired)
    );

    typedef struct {
        int cycles;
        int imem_req_n;
        int ir_we_n;
        int pc_we_n;
        int last_pc_src;
        int reg_we_n;
        int reg_dst;
        int wd_sel;
        int illegal_n;
        int dmem_req_n;
        int dmem_we_n;
        int exec_n;
        int alu_op;
        int alu_src_b;
        bit chk_src_b;
        int ext_op;
        bit chk_ext;
        int retired;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_retired = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: per-instruction totals derived from the instruction's class.
    task automatic model(input int k, input int iw, input int dw, input bit z,
                         input int ret_before, output exp_t e);
        bit mem, jump, rcalc;
        int base;
        mem   = (k == K_LW || k == K_SW);
        jump  = (k == K_J || k == K_JAL || k == K_JR);
        rcalc = (k == K_ADDU || k == K_SUBU || k == K_SLL);
        if (jump || k == K_ILL) base = 2;
        else if (k == K_BEQ)    base = 3;
        else if (k == K_LW)     base = 5;
        else                    base = 4;
        e.cycles      = base + iw + (mem ? dw : 0);
        e.imem_req_n  = iw + 1;
        e.ir_we_n     = 1;
        e.pc_we_n     = 1 + (jump ? 1 : 0) + ((k == K_BEQ && z) ? 1 : 0);
        e.last_pc_src = (k == K_J || k == K_JAL) ? 2 : (k == K_JR) ? 3 : (k == K_BEQ && z) ? 1 : 0;
        e.reg_we_n    = (rcalc || k inside {K_ORI, K_LUI, K_LW, K_JAL}) ? 1 : 0;
        e.reg_dst     = rcalc ? 1 : (k == K_JAL) ? 2 : 0;
        e.wd_sel      = (k == K_LW) ? 1 : (k == K_JAL) ? 2 : 0;
        e.illegal_n   = (k == K_ILL) ? 1 : 0;
        e.dmem_req_n  = mem ? dw + 1 : 0;
        e.dmem_we_n   = (k == K_SW) ? dw + 1 : 0;
        e.exec_n      = (jump || k == K_ILL) ? 0 : 1;
        e.alu_op = 0; e.alu_src_b = 0; e.chk_src_b = 1'b1; e.ext_op = 0; e.chk_ext = 1'b0;
        case (k)
            K_SUBU: e.alu_op = 1;
            K_SLL:  begin e.alu_op = 4; e.chk_src_b = 1'b0; end
            K_ORI:  begin e.alu_op = 2; e.alu_src_b = 1; e.chk_ext = 1'b1; end
            K_LUI:  begin e.alu_op = 3; e.alu_src_b = 1; end
            K_LW, K_SW: begin e.alu_src_b = 1; e.ext_op = 1; e.chk_ext = 1'b1; end
            K_BEQ:  begin e.alu_op = 1; e.ext_op = 1; e.chk_ext = 1'b1; end
            default: ;
        endcase
        e.retired = ret_before + ((k == K_ILL) ? 0 : 1);
    endtask

    task automatic encode(input int k, input int v, output logic [5:0] o, output logic [5:0] f);
        logic [5:0] ill_f [4];
        ill_f[0] = 6'h22; ill_f[1] = 6'h01; ill_f[2] = 6'h3f; ill_f[3] = 6'h20;
        f = 6'($urandom_range(0, 63));
        case (k)
            K_ADDU: begin o = 6'h00; f = 6'h21; end
            K_SUBU: begin o = 6'h00; f = 6'h23; end
            K_SLL:  begin o = 6'h00; f = 6'h00; end
            K_JR:   begin o = 6'h00; f = 6'h08; end
            K_ORI:  o = 6'h0d;
            K_LW:   o = 6'h23;
            K_SW:   o = 6'h2b;
            K_BEQ:  o = 6'h04;
            K_LUI:  o = 6'h0f;
            K_J:    o = 6'h02;
            K_JAL:  o = 6'h03;
            default: begin
                case (v)
                    0: o = 6'h3f;
                    1: o = 6'h08;
                    2: o = 6'h01;
                    default: begin o = 6'h00; f = ill_f[$urandom_range(0, 3)]; end
                endcase
            end
        endcase
    endtask

    // Called at posedge+1 with the DUT in cycle 0 of FETCH.
    task automatic run_instr(input int k, input int v, input int iw, input int dw, input bit z);
        exp_t e;
        logic [5:0] o, f;
        int ms;
        bit mem;
        model(k, iw, dw, z, exp_retired, e);
        exp_retired = e.retired;
        sb_q.push_back(e);
        encode(k, v, o, f);
        op = o; func = f; alu_zero = z;
        mem = (k == K_LW || k == K_SW);
        ms  = iw + 3;
        for (int c = 0; c < e.cycles; c++) begin
            if (c < iw)       imem_ready = 1'b0;
            else if (c == iw) imem_ready = 1'b1;
            else              imem_ready = 1'($urandom_range(0, 1));
            if (mem && c >= ms && c < ms + dw) dmem_ready = 1'b0;
            else if (mem && c == ms + dw)      dmem_ready = 1'b1;
            else                               dmem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    // Monitor: one window per instruction, FETCH entry to next FETCH entry.
    logic [2:0] prev_st;
    int a_cyc, a_imem, a_ir, a_pc, a_src, a_reg, a_rd, a_wd, a_ill, a_dreq, a_dwe;
    int a_exec, a_aop, a_asrc, a_aext, a_membad;

    task automatic clear_acc();
        a_cyc = 0; a_imem = 0; a_ir = 0; a_pc = 0; a_src = 0; a_reg = 0; a_rd = 0;
        a_wd = 0; a_ill = 0; a_dreq = 0; a_dwe = 0; a_exec = 0; a_aop = 0; a_asrc = 0;
        a_aext = 0; a_membad = 0;
    endtask

    task automatic close_window();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb_pop: got an instruction boundary, expected none pending (t=%0t)", $time);
        end else begin
            e = sb_q.pop_front();
            check("cycles", a_cyc, e.cycles);
            check("imem_req_cycles", a_imem, e.imem_req_n);
            check("ir_we_cycles", a_ir, e.ir_we_n);
            check("pc_we_cycles", a_pc, e.pc_we_n);
            check("last_pc_src", a_src, e.last_pc_src);
            check("reg_we_cycles", a_reg, e.reg_we_n);
            check("reg_dst", a_rd, e.reg_dst);
            check("wd_sel", a_wd, e.wd_sel);
            check("illegal_cycles", a_ill, e.illegal_n);
            check("dmem_req_cycles", a_dreq, e.dmem_req_n);
            check("dmem_we_cycles", a_dwe, e.dmem_we_n);
            check("exec_cycles", a_exec, e.exec_n);
            check("mem_sel_bad", a_membad, 0);
            if (e.exec_n != 0) begin
                check("alu_op", a_aop, e.alu_op);
                if (e.chk_src_b) check("alu_src_b", a_asrc, e.alu_src_b);
                if (e.chk_ext)   check("ext_op", a_aext, e.ext_op);
            end
            check("retired", retired, e.retired);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_st = ST_IDLE;
        end else begin
            if (mon_en && state == ST_FETCH && prev_st != ST_FETCH) begin
                if (prev_st != ST_IDLE) close_window();
                clear_acc();
            end
            if (mon_en) begin
                a_cyc++;
                if (imem_req) a_imem++;
                if (ir_we) a_ir++;
                if (pc_we) begin a_pc++; a_src = int'(pc_src); end
                if (reg_we) begin a_reg++; a_rd = int'(reg_dst); a_wd = int'(wd_sel); end
                if (illegal) a_ill++;
                if (dmem_req) a_dreq++;
                if (dmem_we) a_dwe++;
                if (state == ST_EXEC) begin
                    a_exec++; a_aop = int'(alu_op); a_asrc = int'(alu_src_b); a_aext = int'(ext_op);
                end
                if (state == ST_MEM && {alu_op, alu_src_b, ext_op} != 5'b000_1_1) a_membad++;
            end
            prev_st = state;
        end
    end

    task automatic timeout_count(input logic [2:0] st, output int cnt);
        int guard;
        cnt = 0;
        guard = 0;
        while (bus_err !== 1'b1 && guard < 80) begin
            @(posedge clk); #1;
            guard++;
            if (state == st) cnt++;
        end
    endtask

    function automatic logic [17:0] all_outs();
        return {imem_req, dmem_req, dmem_we, pc_we, ir_we, reg_we, alu_op, alu_src_b,
                ext_op, reg_dst, wd_sel, pc_src, illegal};
    endfunction

    initial begin
        int cnt, k, iw, dw;
        reset_n = 1'b0; op = 6'h00; func = 6'h21; alu_zero = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        #3;
        check("rst_state", state, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_retired", retired, 0);
        check("rst_outputs", all_outs(), 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        #1;
        check("idle_after_release", state, ST_IDLE);
        @(posedge clk); #1;

        // directed cases first, then random traffic
        run_instr(K_ADDU, 0, 0, 0, 1'b0);
        run_instr(K_LW,   0, 0, 3, 1'b0);
        run_instr(K_BEQ,  0, 0, 0, 1'b1);
        run_instr(K_BEQ,  0, 0, 0, 1'b0);
        run_instr(K_JAL,  0, 0, 0, 1'b0);
        run_instr(K_ILL,  0, 0, 0, 1'b0);
        run_instr(K_ADDU, 0, TIMEOUT - 1, 0, 1'b0);
        run_instr(K_SW,   0, 0, TIMEOUT - 1, 1'b0);
        run_instr(K_JR,   0, 2, 0, 1'b1);
        for (int n = 0; n < 250; n++) begin
            k  = $urandom_range(0, 11);
            iw = ($urandom_range(0, 7) == 0) ? $urandom_range(3, TIMEOUT - 1) : $urandom_range(0, 2);
            dw = ($urandom_range(0, 7) == 0) ? $urandom_range(3, TIMEOUT - 1) : $urandom_range(0, 2);
            run_instr(k, $urandom_range(0, 3), iw, dw, 1'($urandom_range(0, 1)));
        end
        imem_ready = 1'b0;
        @(negedge clk); #1;
        mon_en = 1'b0;
        check("sb_drained", sb_q.size(), 0);
        check("retired_total", retired, exp_retired);
        check("no_bus_err_at_boundary", bus_err, 0);

        // async reset in the middle of a fetch wait
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_state", state, ST_IDLE);
        check("async_rst_retired", retired, 0);
        check("async_rst_imem_req", imem_req, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // fetch timeout
        timeout_count(ST_FETCH, cnt);
        check("fetch_timeout_bus_err", bus_err, 1);
        check("fetch_timeout_cycles", cnt, TIMEOUT);
        check("fetch_timeout_state", state, ST_IDLE);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("err_idle_state", state, ST_IDLE);
            check("err_idle_outputs", all_outs(), 0);
            check("err_sticky", bus_err, 1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_bus_err", bus_err, 0);

        // data timeout on lw
        op = 6'h23; func = 6'h00; imem_ready = 1'b1; dmem_ready = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        timeout_count(ST_MEM, cnt);
        check("mem_timeout_bus_err", bus_err, 1);
        check("mem_timeout_cycles", cnt, TIMEOUT);
        check("mem_timeout_state", state, ST_IDLE);
        check("mem_timeout_dmem_req", dmem_req, 0);
        check("mem_timeout_retired", retired, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control state machine for the MIPS core.
- Takes the op/func fields that the field splitter extracts from the latched IR. Sequences fetch, decode, execute, memory and writeback.
- Drives PC/IR/GRF write enables, mux selects and the instruction/data memory request handshakes.
- Counts retired instructions and flags illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT, 16, max cycles to wait for imem_ready/dmem_ready before bus_err; must be ≥1.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  6  opcode field of IR (instr[31:26]).
- func  in  6  function field of IR (instr[5:0]).
- alu_zero  in  1  ALU equal flag for beq.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write (valid with dmem_req).
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- reg_we  out  1  GRF write enable.
- alu_op  out  3  0 ADD, 1 SUB, 2 OR, 3 LUI, 4 SLL.
- alu_src_b  out  1  0 rt, 1 extended imm.
- ext_op  out  1  0 zero-ext, 1 sign-ext.
- reg_dst  out  2  0 rt, 1 rd, 2 $31.
- wd_sel  out  2  0 ALU, 1 mem data, 2 PC.
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump26, 3 rs.
- state  out  3  current state.
- illegal  out  1  one-cycle pulse on unknown instruction.
- bus_err  out  1  sticky timeout flag.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Supported instructions:
  - op=0 with func 0x21 addu, 0x23 subu, 0x08 jr, 0x00 sll/nop.
  - op 0x0d ori, 0x23 lw, 0x2b sw, 0x04 beq, 0x0f lui, 0x02 j, 0x03 jal.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. State register is the only storage besides wait counter, bus_err and retired.
- Reset (async, reset_n=0): state=IDLE, wait counter=0, bus_err=0, retired=0.
  - All outputs are combinational from state/op/func; in IDLE every enable and request is 0 and selects are 0.
  - Reset mid-operation aborts immediately; the next step is FETCH.
- IDLE: goes to FETCH next cycle, unless bus_err=1, in which case it stays in IDLE.
- FETCH:
  - imem_req=1.
  - If imem_ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - j: pc_we=1, pc_src=2, go to FETCH, retire.
  - jal: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wd_sel=2 (PC already holds PC+4), go to FETCH, retire.
  - jr: pc_we=1, pc_src=3, go to FETCH, retire.
  - Unknown op/func: illegal=1 for this cycle, no writes, go to FETCH, not counted.
  - Anything else: go to EXEC.
- EXEC selects:
  - addu: alu_op=0, alu_src_b=0.
  - subu: alu_op=1, alu_src_b=0.
  - sll: alu_op=4.
  - ori: alu_op=2, alu_src_b=1, ext_op=0.
  - lui: alu_op=3, alu_src_b=1.
  - lw/sw: alu_op=0, alu_src_b=1, ext_op=1.
  - beq: alu_op=1, alu_src_b=0, ext_op=1.
- EXEC next state:
  - beq: pc_we=alu_zero, pc_src=1, go to FETCH, retire (taken or not).
  - lw/sw: go to MEM.
  - Others: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for sw.
  - Address selects are held as in EXEC.
  - On dmem_ready: sw goes to FETCH and retires; lw goes to WB.
- WB:
  - reg_we=1.
  - R-type: reg_dst=1, wd_sel=0; ori/lui: reg_dst=0, wd_sel=0; lw: reg_dst=0, wd_sel=1.
  - Go to FETCH and retire.
- Wait counter:
  - Increments each cycle in FETCH without imem_ready, or in MEM without dmem_ready.
  - Clears on ready or on leaving the state.
  - When it reaches TIMEOUT-1 with ready still low: bus_err<=1, state<=IDLE, requests drop the next cycle.
  - If ready arrives in the same cycle the count hits TIMEOUT-1, ready wins: normal transition, no error.
- bus_err is sticky until reset. The FSM remains in IDLE with all outputs 0.
- retired increments by 1 on the cycle the instruction's final state transition occurs, and wraps modulo 2^CNT_W.
- Cycle counts with zero-wait memory:
  - j/jal/jr: 2.
  - beq: 3.
  - R-type/ori/lui: 4.
  - sw: 4.
  - lw: 5.

Test Plan:
- Reset release, imem_ready=1, instruction addu (op=0, func=0x21) → states 0,1,2,3,5,1. reg_we=1 only in WB with reg_dst=1. retired=1 after WB.
- lw (op=0x23), dmem_ready delayed 3 cycles → MEM held 4 cycles with dmem_req=1, dmem_we=0; then WB with wd_sel=1; total 8 cycles FETCH→FETCH.
- beq with alu_zero=1, then beq with alu_zero=0 → pc_we=1/pc_src=1 in EXEC for the first and pc_we=0 for the second; retired +2.
- jal (op=0x03) → in DECODE pc_we=1, pc_src=2, reg_we=1, reg_dst=2, wd_sel=2; back to FETCH next cycle.
- op=0x3f → illegal pulses exactly one cycle in DECODE; no pc_we/reg_we; retired unchanged.
- imem_ready held 0 with TIMEOUT=16 → bus_err=1 after 16 FETCH cycles, state=0 thereafter. Asserting reset_n low mid-wait clears bus_err and retired asynchronously.
